// File: rtl/riscv_alu_arb_pkg.sv
// Shared RISC-V constants: data width and ALU control codes, plus the
// response-buffer state type used by riscv_alu_arb.
package riscv_alu_arb_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] ALU_CTRL_ADD  = 5'd0;
    localparam logic [4:0] ALU_CTRL_SUB  = 5'd1;
    localparam logic [4:0] ALU_CTRL_SLL  = 5'd2;
    localparam logic [4:0] ALU_CTRL_SLT  = 5'd3;
    localparam logic [4:0] ALU_CTRL_SLTU = 5'd4;
    localparam logic [4:0] ALU_CTRL_XOR  = 5'd5;
    localparam logic [4:0] ALU_CTRL_SRL  = 5'd6;
    localparam logic [4:0] ALU_CTRL_SRA  = 5'd7;
    localparam logic [4:0] ALU_CTRL_OR   = 5'd8;
    localparam logic [4:0] ALU_CTRL_AND  = 5'd9;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/riscv_alu.sv
// Combinational RV32 integer ALU: result selected by a 5-bit ALU_CTRL_* code,
// plus a zero flag on the result.
module riscv_alu
    import riscv_alu_arb_pkg::*;
(
    input  logic [4:0]      i_alu_ctrl,
    input  logic [XLEN-1:0] i_alu_a,
    input  logic [XLEN-1:0] i_alu_b,
    output logic [XLEN-1:0] o_alu_result,
    output logic            o_alu_zero
);

    // NOTE: every output of an always_comb is given a default first so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        o_alu_result = '0;
        case (i_alu_ctrl)
            ALU_CTRL_ADD:  o_alu_result = i_alu_a + i_alu_b;
            ALU_CTRL_SUB:  o_alu_result = i_alu_a - i_alu_b;
            ALU_CTRL_SLL:  o_alu_result = i_alu_a << i_alu_b[4:0];
            ALU_CTRL_SLT:  o_alu_result = {{(XLEN-1){1'b0}}, $signed(i_alu_a) < $signed(i_alu_b)};
            ALU_CTRL_SLTU: o_alu_result = {{(XLEN-1){1'b0}}, i_alu_a < i_alu_b};
            ALU_CTRL_XOR:  o_alu_result = i_alu_a ^ i_alu_b;
            ALU_CTRL_SRL:  o_alu_result = i_alu_a >> i_alu_b[4:0];
            ALU_CTRL_SRA:  o_alu_result = $signed(i_alu_a) >>> i_alu_b[4:0];
            ALU_CTRL_OR:   o_alu_result = i_alu_a | i_alu_b;
            ALU_CTRL_AND:  o_alu_result = i_alu_a & i_alu_b;
            default:       o_alu_result = '0;
        endcase
    end

    assign o_alu_zero = (o_alu_result == '0);

endmodule

// File: rtl/riscv_rr_arb.sv
// NREQ-way arbiter: one-hot grant plus encoded index. Round-robin by default;
// RISCV_ALU_ARB_FIXED_PRIO_EN selects fixed lowest-index-wins priority.
module riscv_rr_arb #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_advance,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_grant_idx
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] pos;
    logic           found;

`ifdef RISCV_ALU_ARB_FIXED_PRIO_EN
    // A search that always starts at 0 is plain fixed priority.
    assign ptr = '0;

    logic unused_fixed_prio;
    assign unused_fixed_prio = ^{i_clk, i_rst, i_advance};
`else
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of process ordering.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr <= '0;
        end else if (i_advance) begin
            ptr <= (int'(o_grant_idx) == NREQ - 1) ? '0 : o_grant_idx + 1'b1;
        end
    end
`endif

    // Scan NREQ slots starting at the pointer, wrapping past NREQ-1 to 0.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        found       = 1'b0;
        pos         = '0;
        for (int i = 0; i < NREQ; i++) begin
            pos = IDW'((int'(ptr) + i) % NREQ);
            if (!found && i_req[pos]) begin
                found       = 1'b1;
                o_grant[pos] = 1'b1;
                o_grant_idx = pos;
            end
        end
    end

endmodule

// File: rtl/riscv_alu_arb.sv
// Shares one riscv_alu among NREQ valid/ready requesters; the winner's result
// is registered in a one-entry response buffer tagged with the requester id.
// Build option: RISCV_ALU_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
module riscv_alu_arb
    import riscv_alu_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NREQ-1:0]   i_req_valid,
    output logic [NREQ-1:0]   o_req_ready,
    input  logic [NREQ*XLEN-1:0] i_req_a,
    input  logic [NREQ*XLEN-1:0] i_req_b,
    input  logic [NREQ*5-1:0] i_req_ctrl,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [IDW-1:0]    o_rsp_id,
    output logic [XLEN-1:0]   o_rsp_result,
    output logic              o_rsp_zero
);

    buf_state_e      state, state_next;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            accept;
    logic            handshake;
    logic [XLEN-1:0] alu_a, alu_b, alu_result;
    logic [4:0]      alu_ctrl;
    logic            alu_zero;

    riscv_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_req_valid),
        .i_advance   (handshake),
        .o_grant     (grant),
        .o_grant_idx (grant_idx)
    );

    // Ready depends only on valids, buffer state and i_rsp_ready, never on payload.
    assign accept      = (state == BUF_EMPTY) || i_rsp_ready;
    assign o_req_ready = (i_rst || !accept) ? '0 : grant;
    assign handshake   = |o_req_ready;

    assign alu_a    = i_req_a[grant_idx*XLEN +: XLEN];
    assign alu_b    = i_req_b[grant_idx*XLEN +: XLEN];
    assign alu_ctrl = i_req_ctrl[grant_idx*5 +: 5];

    riscv_alu u_alu (
        .i_alu_ctrl   (alu_ctrl),
        .i_alu_a      (alu_a),
        .i_alu_b      (alu_b),
        .o_alu_result (alu_result),
        .o_alu_zero   (alu_zero)
    );

    always_comb begin
        state_next = state;
        if (handshake) begin
            state_next = BUF_FULL;
        end else if (i_rsp_ready) begin
            state_next = BUF_EMPTY;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= BUF_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Payload registers hold their last value after a drain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rsp_id     <= '0;
            o_rsp_result <= '0;
            o_rsp_zero   <= 1'b0;
        end else if (handshake) begin
            o_rsp_id     <= grant_idx;
            o_rsp_result <= alu_result;
            o_rsp_zero   <= alu_zero;
        end
    end

    assign o_rsp_valid = (state == BUF_FULL);

endmodule

// File: tb/tb_riscv_alu_arb.sv
// Self-checking bench for riscv_alu_arb: transaction-level model compared every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_riscv_alu_arb;
    import riscv_alu_arb_pkg::*;

    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic                 i_clk = 1'b0;
    logic                 i_rst;
    logic [NREQ-1:0]      i_req_valid;
    logic [NREQ-1:0]      o_req_ready;
    logic [NREQ*XLEN-1:0] i_req_a;
    logic [NREQ*XLEN-1:0] i_req_b;
    logic [NREQ*5-1:0]    i_req_ctrl;
    logic                 o_rsp_valid;
    logic                 i_rsp_ready;
    logic [IDW-1:0]       o_rsp_id;
    logic [XLEN-1:0]      o_rsp_result;
    logic                 o_rsp_zero;

    riscv_alu_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_a      (i_req_a),
        .i_req_b      (i_req_b),
        .i_req_ctrl   (i_req_ctrl),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_id     (o_rsp_id),
        .o_rsp_result (o_rsp_result),
        .o_rsp_zero   (o_rsp_zero)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (c)
            ALU_CTRL_ADD:  return a + b;
            ALU_CTRL_SUB:  return a - b;
            ALU_CTRL_SLL:  return a << sh;
            ALU_CTRL_SRL:  return a >> sh;
            ALU_CTRL_SRA:  return $signed(a) >>> sh;
            ALU_CTRL_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_CTRL_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_CTRL_XOR:  return a ^ b;
            ALU_CTRL_OR:   return a | b;
            ALU_CTRL_AND:  return a & b;
            default:       return 32'd0;
        endcase
    endfunction

    function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
`ifdef RISCV_ALU_ARB_FIXED_PRIO_EN
        for (int k = 0; k < NREQ; k++) if (v[k]) return k;
`else
        for (int i = 0; i < NREQ; i++) if (v[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
`endif
        return -1;
    endfunction

    // Transaction-level model of the response buffer and arbitration pointer.
    bit          m_on = 1'b0;
    bit          m_valid;
    int          m_id;
    logic [31:0] m_result;
    bit          m_zero;
    int          m_ptr;
    int          cyc = 0;
    int          log_id[$];
    int          log_cyc[$];

    initial begin
        int          win;
        bit          n_valid;
        int          n_id;
        logic [31:0] n_result;
        bit          n_zero;
        int          n_ptr;
        logic [NREQ-1:0] exp_ready;
        forever begin
            @(negedge i_clk);
            win = -1;
            if (!i_rst && (!m_valid || i_rsp_ready)) win = pick(i_req_valid, m_ptr);
            if (m_on) begin
                exp_ready = '0;
                if (win >= 0) exp_ready[win] = 1'b1;
                check("rsp_valid", 32'(o_rsp_valid), 32'(m_valid));
                check("rsp_id", 32'(o_rsp_id), m_id);
                check("rsp_result", o_rsp_result, m_result);
                check("rsp_zero", 32'(o_rsp_zero), 32'(m_zero));
                check("req_ready", 32'(o_req_ready), 32'(exp_ready));
                if (o_rsp_valid && i_rsp_ready && !i_rst) begin
                    log_id.push_back(int'(o_rsp_id));
                    log_cyc.push_back(cyc);
                end
            end
            n_valid = m_valid; n_id = m_id; n_result = m_result; n_zero = m_zero; n_ptr = m_ptr;
            if (i_rst) begin
                n_valid = 0; n_id = 0; n_result = '0; n_zero = 0; n_ptr = 0;
            end else if (win >= 0) begin
                n_valid  = 1;
                n_id     = win;
                n_result = alu_ref(i_req_ctrl[win*5 +: 5], i_req_a[win*XLEN +: XLEN], i_req_b[win*XLEN +: XLEN]);
                n_zero   = (n_result == 0);
                n_ptr    = (win + 1) % NREQ;
            end else if (i_rsp_ready) begin
                n_valid = 0;
            end
            @(posedge i_clk);
            if (m_on || i_rst) begin
                m_valid = n_valid; m_id = n_id; m_result = n_result; m_zero = n_zero; m_ptr = n_ptr;
            end
            if (i_rst) m_on = 1'b1;
            cyc++;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_req(input int k, input bit v, input logic [31:0] a, input logic [31:0] b, input logic [4:0] c);
        i_req_valid[k]        = v;
        i_req_a[k*XLEN +: XLEN] = a;
        i_req_b[k*XLEN +: XLEN] = b;
        i_req_ctrl[k*5 +: 5]  = c;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
    endtask

    // Issue one op on requester k; returns the response visible the cycle after handshake.
    task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b, input logic [4:0] c,
                         output logic [31:0] res, output bit z, output int id, output bit v);
        bit got;
        got = 1'b0;
        set_req(k, 1'b1, a, b, c);
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge i_clk);
            if (o_req_ready[k]) got = 1'b1;
            else tick();
        end
        check("issue_handshake", 32'(got), 32'd1);
        tick();
        i_req_valid[k] = 1'b0;
        @(negedge i_clk);
        res = o_rsp_result;
        z   = o_rsp_zero;
        id  = int'(o_rsp_id);
        v   = o_rsp_valid;
        tick();
    endtask

    typedef struct {
        logic [4:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        bit          z, v;
        int          id;
        int          exp3[4];

        vecs[0] = '{ALU_CTRL_SUB,  32'd7,          32'd7,          32'h0000_0000};
        vecs[1] = '{ALU_CTRL_SRA,  32'h8000_0000,  32'd33,         32'hC000_0000};
        vecs[2] = '{ALU_CTRL_SLT,  32'hFFFF_FFFF,  32'd1,          32'h0000_0001};
        vecs[3] = '{ALU_CTRL_SLTU, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000};
        vecs[4] = '{ALU_CTRL_SLL,  32'd1,          32'd36,         32'h0000_0010};
        vecs[5] = '{ALU_CTRL_SRL,  32'h8000_0000,  32'd31,         32'h0000_0001};
        vecs[6] = '{ALU_CTRL_XOR,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_0FF0};
        vecs[7] = '{ALU_CTRL_OR,   32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF};
        vecs[8] = '{ALU_CTRL_AND,  32'h0000_00F0,  32'h0000_003C,  32'h0000_0030};
        vecs[9] = '{ALU_CTRL_ADD,  32'hFFFF_FFFF,  32'd1,          32'h0000_0000};

        // Reset held two cycles with both requesters valid.
        i_rst       = 1'b1;
        i_rsp_ready = 1'b1;
        i_req_valid = '0;
        i_req_a     = '0;
        i_req_b     = '0;
        i_req_ctrl  = '0;
        set_req(0, 1'b1, 32'd1, 32'd1, ALU_CTRL_ADD);
        set_req(1, 1'b1, 32'd2, 32'd2, ALU_CTRL_ADD);
        for (int n = 0; n < 2; n++) begin
            tick();
            @(negedge i_clk);
            check("t1_ready", 32'(o_req_ready), 32'd0);
            check("t1_valid", 32'(o_rsp_valid), 32'd0);
            check("t1_result", o_rsp_result, 32'd0);
        end
        tick();
        i_rst       = 1'b0;
        i_req_valid = '0;
        tick();

        // Single ADD on requester 0.
        issue(0, 32'd5, 32'd3, ALU_CTRL_ADD, res, z, id, v);
        check("t2_valid", 32'(v), 32'd1);
        check("t2_result", res, 32'd8);
        check("t2_zero", 32'(z), 32'd0);
        check("t2_id", id, 32'd0);

        // Both requesters valid continuously: one response per cycle.
        do_reset();
        log_id.delete();
        log_cyc.delete();
        set_req(0, 1'b1, 32'd10, 32'd1, ALU_CTRL_ADD);
        set_req(1, 1'b1, 32'd20, 32'd2, ALU_CTRL_SUB);
        repeat (4) tick();
        i_req_valid = '0;
        repeat (3) tick();
`ifdef RISCV_ALU_ARB_FIXED_PRIO_EN
        exp3 = '{0, 0, 0, 0};
`else
        exp3 = '{0, 1, 0, 1};
`endif
        check("t3_count", log_id.size(), 32'd4);
        if (log_id.size() == 4) begin
            for (int i = 0; i < 4; i++) check("t3_grant_order", log_id[i], exp3[i]);
            check("t3_back_to_back", log_cyc[3] - log_cyc[0], 32'd3);
        end

        // Backpressure, then same-cycle drain and refill.
        do_reset();
        i_rsp_ready = 1'b0;
        issue(0, 32'd1, 32'd2, ALU_CTRL_ADD, res, z, id, v);
        check("t4_first_result", res, 32'd3);
        set_req(1, 1'b1, 32'd100, 32'd23, ALU_CTRL_ADD);
        for (int n = 0; n < 3; n++) begin
            @(negedge i_clk);
            check("t4_hold_ready", 32'(o_req_ready), 32'd0);
            check("t4_hold_valid", 32'(o_rsp_valid), 32'd1);
            check("t4_hold_result", o_rsp_result, 32'd3);
            tick();
        end
        i_rsp_ready = 1'b1;
        @(negedge i_clk);
        check("t4_refill_ready", 32'(o_req_ready), 32'b10);
        tick();
        i_req_valid[1] = 1'b0;
        @(negedge i_clk);
        check("t4_nobubble_valid", 32'(o_rsp_valid), 32'd1);
        check("t4_nobubble_id", 32'(o_rsp_id), 32'd1);
        check("t4_nobubble_result", o_rsp_result, 32'd123);
        tick();

        // Operation and boundary vectors on requester 1.
        for (int i = 0; i < 10; i++) begin
            issue(1, vecs[i].a, vecs[i].b, vecs[i].c, res, z, id, v);
            check("t5_result", res, vecs[i].r);
            check("t5_zero", 32'(z), 32'(vecs[i].r == 0));
            check("t5_id", id, 32'd1);
        end

        // Reset while a response is held under backpressure.
        do_reset();
        i_rsp_ready = 1'b0;
        issue(0, 32'd9, 32'd9, ALU_CTRL_ADD, res, z, id, v);
        tick();
        log_id.delete();
        i_rst = 1'b1;
        set_req(0, 1'b1, 32'd4, 32'd4, ALU_CTRL_ADD);
        set_req(1, 1'b1, 32'd6, 32'd1, ALU_CTRL_SUB);
        @(negedge i_clk);
        check("t6_rst_ready", 32'(o_req_ready), 32'd0);
        tick();
        i_rst       = 1'b0;
        i_rsp_ready = 1'b1;
        @(negedge i_clk);
        check("t6_valid_cleared", 32'(o_rsp_valid), 32'd0);
        check("t6_ptr_reset", 32'(o_req_ready), 32'b01);
        tick();
        i_req_valid[0] = 1'b0;
        @(negedge i_clk);
        check("t6_first_result", o_rsp_result, 32'd8);
        tick();
        i_req_valid[1] = 1'b0;
        repeat (3) tick();
        check("t6_rsp_count", log_id.size(), 32'd2);
        if (log_id.size() == 2) begin
            check("t6_rsp0_id", log_id[0], 32'd0);
            check("t6_rsp1_id", log_id[1], 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
